// File: rtl/sequence_frame_tx_if.sv
// Payload handshake between a producer and the sequence frame transmitter.
interface sequence_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/sequence_frame_tx.sv
// Serialises one payload word per frame: sync header, payload MSB first,
// optional even parity, then a run of forced-zero gap bits.
module sequence_frame_tx #(
    parameter int         DATA_W    = 8,
    parameter int         GAP_BITS  = 2,
    parameter int         PARITY_EN = 0,
    parameter logic [3:0] HEADER    = 4'b1001
) (
    input  logic                clk,
    input  logic                rst,
    sequence_frame_tx_if.slave  bus,
    output logic                x,
    output logic                busy,
    output logic                frame_done
);
    localparam int MAX_A  = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAX_C  = (GAP_BITS > MAX_A) ? GAP_BITS : MAX_A;
    localparam int CNT_W  = $clog2(MAX_C);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              par_r;
    logic              x_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              ready_s;
    logic              accept_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign ready_s       = (state_r == ST_IDLE);
    assign accept_s      = bus.din_valid && ready_s;
    assign bus.din_ready = ready_s;
    assign x             = x_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;

    // Frame sequencer; cnt_r holds the cycles left in the current state after this one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            shift_r      <= '0;
            par_r        <= 1'b0;
            x_r          <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= ST_HDR;
                        cnt_r   <= CNT_HDR;
                        shift_r <= bus.din;
                        par_r   <= even_parity(bus.din);
                        x_r     <= HEADER[3];
                        busy_r  <= 1'b1;
                    end else begin
                        x_r    <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        x_r   <= HEADER[cnt_r[1:0] - 2'd1];
                    end else begin
                        state_r <= ST_DATA;
                        cnt_r   <= CNT_DATA;
                        x_r     <= shift_r[DATA_W-1];
                        shift_r <= shift_r << 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_r != '0) begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        x_r     <= shift_r[DATA_W-1];
                        shift_r <= shift_r << 1'b1;
                    end else if (PARITY_EN != 0) begin
                        state_r <= ST_PAR;
                        cnt_r   <= '0;
                        x_r     <= par_r;
                    end else begin
                        state_r <= ST_GAP;
                        cnt_r   <= CNT_GAP;
                        x_r     <= 1'b0;
                    end
                end
                ST_PAR: begin
                    state_r <= ST_GAP;
                    cnt_r   <= CNT_GAP;
                    x_r     <= 1'b0;
                end
                ST_GAP: begin
                    x_r <= 1'b0;
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= '0;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    x_r          <= 1'b0;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_frame_tx.sv
// Self-checking bench: fixed frame vectors, multi-cycle corner cases and
// random frames compared against a bit-list model of the frame format.
module tb_sequence_frame_tx;
    localparam logic [3:0] HDR_C = 4'b1001;
    localparam int         GAP_C = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sequence_frame_tx_if #(.DATA_W(8)) bus0 ();
    sequence_frame_tx_if #(.DATA_W(8)) bus1 ();
    logic x0, busy0, fd0, x1, busy1, fd1;

    sequence_frame_tx #(.DATA_W(8), .GAP_BITS(GAP_C), .PARITY_EN(0), .HEADER(HDR_C)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .x(x0), .busy(busy0), .frame_done(fd0));
    sequence_frame_tx #(.DATA_W(8), .GAP_BITS(GAP_C), .PARITY_EN(1), .HEADER(HDR_C)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .x(x1), .busy(busy1), .frame_done(fd1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [7:0] din;
        logic [14:0] exp;
        int         len;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_x(input int sel);
        return (sel == 1) ? x1 : x0;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy0;
    endfunction
    function automatic logic get_fd(input int sel);
        return (sel == 1) ? fd1 : fd0;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel == 1) ? bus1.din_ready : bus0.din_ready;
    endfunction

    task automatic drive(input int sel, input logic [7:0] d, input logic v);
        if (sel == 1) begin
            bus1.din = d;
            bus1.din_valid = v;
        end else begin
            bus0.din = d;
            bus0.din_valid = v;
        end
    endtask

    // Reference: list of transmitted bits, bit k of 'bits' is the k-th bit on the line.
    function automatic void model_frame(input logic [7:0] d, input bit par,
                                        output logic [63:0] bits, output int len);
        bits = '0;
        len = 0;
        for (int i = 3; i >= 0; i--) begin bits[len] = HDR_C[i]; len++; end
        for (int i = 7; i >= 0; i--) begin bits[len] = d[i]; len++; end
        if (par) begin bits[len] = (($countones(d) % 2) == 1); len++; end
        for (int i = 0; i < GAP_C; i++) begin bits[len] = 1'b0; len++; end
    endfunction

    function automatic logic [63:0] table_bits(input logic [14:0] exp, input int len);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < len; i++) b[i] = exp[len-1-i];
        return b;
    endfunction

    task automatic check_stream(input int sel, input logic [63:0] b, input int len, input bit junk, input string tag);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s x bit%0d", tag, i), get_x(sel), b[i]);
            check($sformatf("%s busy bit%0d", tag, i), get_busy(sel), 1);
            check($sformatf("%s ready bit%0d", tag, i), get_ready(sel), 0);
            check($sformatf("%s done bit%0d", tag, i), get_fd(sel), 0);
            if (junk) drive(sel, 8'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(sel, 8'h00, 1'b0);
        check({tag, " done pulse"}, get_fd(sel), 1);
        check({tag, " idle busy"}, get_busy(sel), 0);
        check({tag, " idle ready"}, get_ready(sel), 1);
        check({tag, " idle x"}, get_x(sel), 0);
        tick();
        check({tag, " done clear"}, get_fd(sel), 0);
    endtask

    task automatic run_frame(input int sel, input logic [7:0] d, input logic [63:0] b,
                             input int len, input bit junk, input string tag);
        int n = 0;
        while (get_ready(sel) !== 1'b1 && n < 50) begin tick(); n++; end
        check({tag, " ready before"}, get_ready(sel), 1);
        drive(sel, d, 1'b1);
        tick();
        drive(sel, 8'h00, 1'b0);
        check_stream(sel, b, len, junk, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        logic [63:0] b;
        logic [63:0] b2;
        int          len;
        int          acc[$];

        vecs[0] = '{0, 8'hA5, 15'b0_1001_10100101_00, 14};
        vecs[1] = '{0, 8'h3C, 15'b0_1001_00111100_00, 14};
        vecs[2] = '{0, 8'h81, 15'b0_1001_10000001_00, 14};
        vecs[3] = '{0, 8'h00, 15'b0_1001_00000000_00, 14};
        vecs[4] = '{0, 8'hFF, 15'b0_1001_11111111_00, 14};
        vecs[5] = '{1, 8'h07, 15'b1001_00000111_1_00, 15};

        // Reset held with a pending payload: nothing is accepted.
        rst = 1'b0;
        drive(0, 8'hA5, 1'b1);
        drive(1, 8'hA5, 1'b1);
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset x%0d", s), get_x(s), 0);
            check($sformatf("reset ready%0d", s), get_ready(s), 1);
            check($sformatf("reset busy%0d", s), get_busy(s), 0);
            check($sformatf("reset done%0d", s), get_fd(s), 0);
        end
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].sel, vecs[v].din, table_bits(vecs[v].exp, vecs[v].len),
                      vecs[v].len, 1'b0, $sformatf("vec%0d", v));
        end

        // Back-to-back frames with din_valid held high.
        drive(0, 8'h3C, 1'b1);
        for (int c = 0; c < 60 && acc.size() < 2; c++) begin
            if (get_ready(0) === 1'b1) acc.push_back(c);
            tick();
            if (acc.size() == 1) bus0.din = 8'h81;
        end
        drive(0, 8'h00, 1'b0);
        check("b2b accepts", acc.size(), 2);
        if (acc.size() == 2) check("b2b spacing", acc[1] - acc[0], 15);
        check_stream(0, table_bits(vecs[2].exp, 14), 14, 1'b0, "b2b second");

        // Payload offered while busy is ignored until the next IDLE cycle.
        while (get_ready(0) !== 1'b1) tick();
        drive(0, 8'h00, 1'b1);
        tick();
        drive(0, 8'hFF, 1'b1);
        b = table_bits(vecs[3].exp, 14);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("busyin x bit%0d", i), x0, b[i]);
            check($sformatf("busyin ready bit%0d", i), bus0.din_ready, 0);
            tick();
        end
        check("busyin done", fd0, 1);
        check("busyin ready idle", bus0.din_ready, 1);
        tick();
        drive(0, 8'h00, 1'b0);
        check_stream(0, table_bits(vecs[4].exp, 14), 14, 1'b0, "busyin ff");

        // Reset during the 4th data bit aborts the frame.
        run_frame(0, 8'h3C, table_bits(vecs[1].exp, 14), 14, 1'b0, "pre");
        drive(0, 8'hA5, 1'b1);
        tick();
        drive(0, 8'h00, 1'b0);
        repeat (7) tick();
        check("midrst busy before", busy0, 1);
        rst = 1'b0;
        #1;
        check("midrst x", x0, 0);
        check("midrst busy", busy0, 0);
        check("midrst ready", bus0.din_ready, 1);
        check("midrst done", fd0, 0);
        repeat (16) begin
            tick();
            check("midrst no done", fd0, 0);
        end
        rst = 1'b1;
        run_frame(0, 8'hA5, table_bits(vecs[0].exp, 14), 14, 1'b0, "postrst");

        // Random frames against the model, with junk offered mid-frame.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            int sel;
            sel = k % 2;
            d = 8'($urandom);
            model_frame(d, (sel == 1), b2, len);
            repeat ($urandom_range(0, 3)) tick();
            run_frame(sel, d, b2, len, 1'b1, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
